// File: rtl/game_pkg.sv
// Shared types, geometry defaults and the paddle-step helper for the catch game.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam logic [1:0] MOVE_RIGHT = 2'b01;
    localparam logic [1:0] MOVE_LEFT  = 2'b10;

    localparam int COORD_W = 11;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_PLAYER_W    = 64;
    localparam int DEF_PLAYER_Y    = 440;
    localparam int DEF_OBJ_W       = 32;
    localparam int DEF_OBJ_H       = 32;
    localparam int DEF_PLAYER_STEP = 4;
    localparam int DEF_FALL_DIV    = 2;
    localparam int DEF_HIT_FRAMES  = 30;
    localparam int DEF_START_LIVES = 3;
    localparam int DEF_SCORE_W     = 10;

    // Next paddle column: clamped at both screen edges, computed 12 bits wide so it never wraps.
    function automatic logic [COORD_W-1:0] paddle_next(
        input logic [COORD_W-1:0] x,
        input logic [1:0]         mv,
        input int                 step,
        input int                 max_x
    );
        logic [COORD_W:0] wide;
        logic [COORD_W-1:0] result;
        wide   = '0;
        result = x;
        case (mv)
            MOVE_RIGHT: begin
                wide = {1'b0, x} + (COORD_W+1)'(step);
                if (wide > (COORD_W+1)'(max_x)) begin
                    wide = (COORD_W+1)'(max_x);
                end
                result = wide[COORD_W-1:0];
            end
            MOVE_LEFT: begin
                if (x < COORD_W'(step)) begin
                    result = '0;
                end else begin
                    result = x - COORD_W'(step);
                end
            end
            default: result = x;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/hit_detect.sv
// Combinational landing / horizontal-overlap test between the falling object and the paddle.
module hit_detect
    import game_pkg::*;
#(
    parameter int PLAYER_W = DEF_PLAYER_W,
    parameter int PLAYER_Y = DEF_PLAYER_Y,
    parameter int OBJ_W    = DEF_OBJ_W,
    parameter int OBJ_H    = DEF_OBJ_H
) (
    input  logic [COORD_W-1:0] object_x,
    input  logic [COORD_W-1:0] object_y,
    input  logic [COORD_W-1:0] player_x,
    output logic               land,
    output logic               overlap
);

    logic [COORD_W:0] obj_bottom;
    logic [COORD_W:0] obj_right;
    logic [COORD_W:0] player_right;
    logic [COORD_W:0] obj_left;
    logic [COORD_W:0] player_left;

    // One extra bit on every sum keeps the edges honest near the right of the screen.
    assign obj_bottom   = {1'b0, object_y} + (COORD_W+1)'(OBJ_H);
    assign obj_right    = {1'b0, object_x} + (COORD_W+1)'(OBJ_W);
    assign player_right = {1'b0, player_x} + (COORD_W+1)'(PLAYER_W);
    assign obj_left     = {1'b0, object_x};
    assign player_left  = {1'b0, player_x};

    assign land    = (obj_bottom >= (COORD_W+1)'(PLAYER_Y));
    assign overlap = (obj_left < player_right) && (obj_right > player_left);

endmodule

// File: rtl/game_controller.sv
// Catch-game sequencer: IDLE/PLAY/HIT/OVER FSM, paddle, fall pacing, catch/miss, score and lives.
module game_controller
    import game_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int PLAYER_W    = DEF_PLAYER_W,
    parameter int PLAYER_Y    = DEF_PLAYER_Y,
    parameter int OBJ_W       = DEF_OBJ_W,
    parameter int OBJ_H       = DEF_OBJ_H,
    parameter int PLAYER_STEP = DEF_PLAYER_STEP,
    parameter int FALL_DIV    = DEF_FALL_DIV,
    parameter int HIT_FRAMES  = DEF_HIT_FRAMES,
    parameter int START_LIVES = DEF_START_LIVES,
    parameter int SCORE_W     = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [1:0]         move,
    input  logic [COORD_W-1:0] object_x,
    input  logic [COORD_W-1:0] object_y,
    output logic               object_step,
    output logic               object_spawn,
    output logic [COORD_W-1:0] player_x,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic [1:0]         state,
    output logic               game_over
);

    localparam int MAX_X   = SCREEN_W - PLAYER_W;
    localparam int CENTRE  = (SCREEN_W - PLAYER_W) / 2;
    localparam int DIV_W   = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
    localparam int TIMER_W = $clog2(HIT_FRAMES + 1);

    localparam logic [COORD_W-1:0] CENTRE_X    = COORD_W'(CENTRE);
    localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(FALL_DIV - 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(HIT_FRAMES);
    localparam logic [1:0]         LIVES_LOAD  = 2'(START_LIVES);

    state_t               state_reg;
    logic [COORD_W-1:0]   player_x_reg;
    logic [SCORE_W-1:0]   score_reg;
    logic [1:0]           lives_reg;
    logic [DIV_W-1:0]     div_reg;
    logic [TIMER_W-1:0]   timer_reg;
    logic                 step_reg;
    logic                 spawn_reg;
    logic                 game_over_reg;

    logic                 land;
    logic                 overlap;
    logic [COORD_W-1:0]   player_x_next;

    hit_detect #(
        .PLAYER_W (PLAYER_W),
        .PLAYER_Y (PLAYER_Y),
        .OBJ_W    (OBJ_W),
        .OBJ_H    (OBJ_H)
    ) u_hit_detect (
        .object_x (object_x),
        .object_y (object_y),
        .player_x (player_x_reg),
        .land     (land),
        .overlap  (overlap)
    );

    assign player_x_next = paddle_next(player_x_reg, move, PLAYER_STEP, MAX_X);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            player_x_reg  <= CENTRE_X;
            score_reg     <= '0;
            lives_reg     <= LIVES_LOAD;
            div_reg       <= '0;
            timer_reg     <= '0;
            step_reg      <= 1'b0;
            spawn_reg     <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            step_reg  <= 1'b0;
            spawn_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_OVER: begin
                    // start wins over any frame_tick arriving in the same cycle.
                    if (start) begin
                        state_reg     <= ST_PLAY;
                        score_reg     <= '0;
                        lives_reg     <= LIVES_LOAD;
                        player_x_reg  <= CENTRE_X;
                        div_reg       <= '0;
                        spawn_reg     <= 1'b1;
                        game_over_reg <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        if (land && overlap) begin
                            if (score_reg != '1) begin
                                score_reg <= score_reg + 1'b1;
                            end
                            spawn_reg    <= 1'b1;
                            div_reg      <= '0;
                            player_x_reg <= player_x_next;
                        end else if (land) begin
                            // Miss frame: paddle stays where the object landed.
                            lives_reg <= lives_reg - 1'b1;
                            if (lives_reg == 2'd1) begin
                                state_reg     <= ST_OVER;
                                game_over_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_HIT;
                                timer_reg <= TIMER_LOAD;
                            end
                        end else begin
                            if (div_reg == DIV_LAST) begin
                                step_reg <= 1'b1;
                                div_reg  <= '0;
                            end else begin
                                div_reg <= div_reg + 1'b1;
                            end
                            player_x_reg <= player_x_next;
                        end
                    end
                end
                ST_HIT: begin
                    if (frame_tick) begin
                        if (timer_reg <= TIMER_W'(1)) begin
                            timer_reg <= '0;
                            state_reg <= ST_PLAY;
                            spawn_reg <= 1'b1;
                        end else begin
                            timer_reg <= timer_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign object_step  = step_reg;
    assign object_spawn = spawn_reg;
    assign player_x     = player_x_reg;
    assign score        = score_reg;
    assign lives        = lives_reg;
    assign state        = state_reg;
    assign game_over    = game_over_reg;

endmodule

// File: tb/tb_game_controller.sv
// Directed, table-driven bench for game_controller plus hand-written multi-frame sequences.
module tb_game_controller;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        start;
    logic [1:0]  move;
    logic [10:0] object_x;
    logic [10:0] object_y;
    logic        object_step;
    logic        object_spawn;
    logic [10:0] player_x;
    logic [9:0]  score;
    logic [1:0]  lives;
    logic [1:0]  state;
    logic        game_over;

    int n_cmp;
    int n_bad;

    game_controller dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start        (start),
        .move         (move),
        .object_x     (object_x),
        .object_y     (object_y),
        .object_step  (object_step),
        .object_spawn (object_spawn),
        .player_x     (player_x),
        .score        (score),
        .lives        (lives),
        .state        (state),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        tk;
        logic [1:0]  mv;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [1:0]  e_state;
        logic [10:0] e_px;
        logic [9:0]  e_score;
        logic [1:0]  e_lives;
        logic        e_step;
        logic        e_spawn;
        logic        e_go;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at a falling edge; outputs are sampled at the next falling edge.
    task automatic cycle(input logic st, input logic tk, input logic [1:0] mv,
                         input logic [10:0] ox, input logic [10:0] oy);
        start      = st;
        frame_tick = tk;
        move       = mv;
        object_x   = ox;
        object_y   = oy;
        @(negedge clk);
        start      = 1'b0;
        frame_tick = 1'b0;
        move       = 2'b00;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_state, input logic [10:0] e_px,
                           input logic [9:0] e_score, input logic [1:0] e_lives,
                           input logic e_step, input logic e_spawn, input logic e_go);
        chk({tag, ".state"}, int'(state), int'(e_state));
        chk({tag, ".player_x"}, int'(player_x), int'(e_px));
        chk({tag, ".score"}, int'(score), int'(e_score));
        chk({tag, ".lives"}, int'(lives), int'(e_lives));
        chk({tag, ".step"}, int'(object_step), int'(e_step));
        chk({tag, ".spawn"}, int'(object_spawn), int'(e_spawn));
        chk({tag, ".game_over"}, int'(game_over), int'(e_go));
        $display("txn %s: state=%0d px=%0d score=%0d lives=%0d step=%0b spawn=%0b go=%0b",
                 tag, state, player_x, score, lives, object_step, object_spawn, game_over);
    endtask

    initial begin
        int bad_mono;
        int prev_px;
        int steps;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        move       = 2'b00;
        object_x   = '0;
        object_y   = '0;

        //              st   tk   mv     ox   oy   state px   sc lv step spawn go
        vecs[0]  = '{1'b1, 1'b1, 2'b00,   0,   0, 2'd1, 288, 0, 3, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b00,   0,   0, 2'd1, 288, 0, 3, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'b01,   0,   0, 2'd1, 292, 0, 3, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'b01,   0,   0, 2'd1, 296, 0, 3, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'b01,   0,   0, 2'd1, 296, 0, 3, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b10,   0,   0, 2'd1, 292, 0, 3, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b11,   0,   0, 2'd1, 292, 0, 3, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 300, 408, 2'd1, 296, 1, 3, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b00,   0,   0, 2'd1, 296, 1, 3, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b00,   0,   0, 2'd1, 296, 1, 3, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b01,   0, 420, 2'd2, 296, 1, 2, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'b01,   0, 420, 2'd2, 296, 1, 2, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk_all("reset", 2'd0, 11'd288, 10'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].st, vecs[i].tk, vecs[i].mv, vecs[i].ox, vecs[i].oy);
            chk_all($sformatf("v%0d", i), vecs[i].e_state, vecs[i].e_px, vecs[i].e_score,
                    vecs[i].e_lives, vecs[i].e_step, vecs[i].e_spawn, vecs[i].e_go);
        end

        // Remaining 29 freeze frames of the HIT period (one already consumed by v11).
        bad_mono = 0;
        for (int i = 0; i < 28; i++) begin
            cycle(1'b0, 1'b1, 2'b01, 0, 0);
            if (state != 2'd2 || object_spawn != 1'b0 || player_x != 11'd296) bad_mono++;
        end
        chk("hit_hold", bad_mono, 0);
        cycle(1'b0, 1'b1, 2'b00, 0, 0);
        chk_all("hit_exit", 2'd1, 11'd296, 10'd1, 2'd2, 1'b0, 1'b1, 1'b0);

        // Paddle clamps at the right edge, then at the left, never wrapping.
        bad_mono = 0;
        prev_px  = int'(player_x);
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b1, 2'b01, 0, 0);
            if (int'(player_x) < prev_px || int'(player_x) > 576) bad_mono++;
            prev_px = int'(player_x);
        end
        chk("right_mono", bad_mono, 0);
        chk("right_clamp", int'(player_x), 576);
        bad_mono = 0;
        steps    = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b1, 2'b10, 0, 0);
            if (int'(player_x) > prev_px) bad_mono++;
            prev_px = int'(player_x);
            if (object_step) steps++;
        end
        chk("left_mono", bad_mono, 0);
        chk("left_clamp", int'(player_x), 0);
        chk("step_count", steps, 100);

        // Two more misses: the first enters HIT, the second ends the game.
        cycle(1'b0, 1'b1, 2'b01, 500, 420);
        chk_all("miss2", 2'd2, 11'd0, 10'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 29; i++) cycle(1'b0, 1'b1, 2'b00, 0, 0);
        chk("hit2_hold", int'(state), 2);
        cycle(1'b0, 1'b1, 2'b00, 0, 0);
        chk_all("hit2_exit", 2'd1, 11'd0, 10'd1, 2'd1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 2'b01, 500, 420);
        chk_all("over", 2'd3, 11'd0, 10'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 2'b01, 0, 0);
        chk_all("over_hold", 2'd3, 11'd0, 10'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 2'b01, 500, 420);
        chk_all("restart", 2'd1, 11'd288, 10'd0, 2'd3, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 0, 0);
        chk("spawn_1cyc", int'(object_spawn), 0);

        // Score saturates at all-ones.
        for (int i = 0; i < 1024; i++) begin
            cycle(1'b0, 1'b1, 2'b00, 300, 408);
            if (i == 9) chk("score10", int'(score), 10);
        end
        chk_all("saturate", 2'd1, 11'd288, 10'd1023, 2'd3, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a game takes effect without a clock edge.
        cycle(1'b0, 1'b1, 2'b01, 0, 0);
        chk("pre_reset_px", int'(player_x), 292);
        rst = 1'b0;
        #1;
        chk_all("mid_reset", 2'd0, 11'd288, 10'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 1'b1, 2'b01, 0, 0);
        chk_all("post_reset", 2'd0, 11'd288, 10'd0, 2'd3, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
